// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit add/subtract sequencer for one shared 4-bit adder slice.
// One nibble per cycle, LSB nibble first, valid/ready on command and result.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             slice_cin,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    input  logic [3:0]       slice_sum,
    input  logic             slice_cout,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             sub_reg;
    logic             carry_reg;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] res_next;
    logic             running;

    assign running = (state == RUN);

    // Result as it will look once the current nibble is written back
    always_comb begin
        res_next = result;
        res_next[4*idx +: 4] = slice_sum;
    end

    assign slice_a   = running ? a_reg[4*idx +: 4] : 4'h0;
    assign slice_b   = running ? b_reg[4*idx +: 4] : 4'h0;
    assign slice_cin = running && ((idx == '0) ? sub_reg : carry_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            start_ready  <= 1'b1;
            result_valid <= 1'b0;
            result       <= '0;
            carry_out    <= 1'b0;
            overflow     <= 1'b0;
            zero         <= 1'b0;
            idx          <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            sub_reg      <= 1'b0;
            carry_reg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_reg       <= op_a;
                        b_reg       <= sub ? ~op_b : op_b;
                        sub_reg     <= sub;
                        carry_reg   <= 1'b0;
                        result      <= '0;
                        idx         <= '0;
                        start_ready <= 1'b0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    result    <= res_next;
                    carry_reg <= slice_cout;
                    if (idx == LAST) begin
                        idx          <= '0;
                        state        <= DONE;
                        result_valid <= 1'b1;
                        carry_out    <= slice_cout;
                        overflow     <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                        (slice_sum[3] != a_reg[WIDTH-1]);
                        zero         <= (res_next == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        start_ready  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: models the external 4-bit adder and
// checks results against whole-word arithmetic.
module tb_nibble_serial_adder_ctrl;

    localparam int W = 32;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         sub = 1'b0;
    logic         slice_cin;
    logic [3:0]   slice_a;
    logic [3:0]   slice_b;
    logic [3:0]   slice_sum;
    logic         slice_cout;
    logic         result_valid;
    logic         result_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // External full_adder_4bit
    assign {slice_cout, slice_sum} = 5'(slice_a) + 5'(slice_b) + 5'(slice_cin);

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .op_a(op_a),
        .op_b(op_b),
        .sub(sub),
        .slice_cin(slice_cin),
        .slice_a(slice_a),
        .slice_b(slice_b),
        .slice_sum(slice_sum),
        .slice_cout(slice_cout),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result(result),
        .carry_out(carry_out),
        .overflow(overflow),
        .zero(zero)
    );

    // {result, carry, overflow, zero} from whole-word arithmetic
    function automatic logic [34:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ex;
        logic [31:0] r;
        logic c;
        logic v;
        if (s) begin
            r  = a - b;
            c  = (ua >= ub);
            ex = sa - sb;
        end else begin
            r  = a + b;
            c  = (ua + ub) > 64'sd4294967295;
            ex = sa + sb;
        end
        v = (ex > MAXS) || (ex < MINS);
        return {r, c, v, (r == 32'h0)};
    endfunction

    task automatic do_accept(input logic [31:0] a, input logic [31:0] b,
                             input logic s);
        int n = 0;
        op_a = a;
        op_b = b;
        sub = s;
        start_valid = 1'b1;
        while (!start_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_result(output int lat, output logic [34:0] obs);
        lat = 0;
        while (!result_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!result_valid) lat = -1;
        obs = {result, carry_out, overflow, zero};
    endtask

    task automatic do_handshake();
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({start_ready, result_valid, result, carry_out, overflow, zero} !==
            {1'b1, 1'b0, 32'h0, 3'b000}) begin
            fails++;
            $display("FAIL reset: rdy=%b vld=%b res=%h c=%b v=%b z=%b want 1 0 0 0 0 0",
                     start_ready, result_valid, result, carry_out, overflow, zero);
        end
        tests++;
        if ({slice_a, slice_b, slice_cin} !== 9'h0) begin
            fails++;
            $display("FAIL reset_slices: a=%h b=%h cin=%b want 0", slice_a, slice_b, slice_cin);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] ta[6] = '{32'h1, 32'hFFFFFFFF, 32'h5, 32'h7FFFFFFF, 32'h80000000, 32'h0};
        logic [31:0] tb[6] = '{32'h3, 32'h1, 32'h7, 32'h1, 32'h1, 32'h0};
        logic        ts[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int lat;
        logic [34:0] obs, exp;
        for (int i = 0; i < 6; i++) begin
            do_accept(ta[i], tb[i], ts[i]);
            wait_result(lat, obs);
            exp = model(ta[i], tb[i], ts[i]);
            tests++;
            if (lat !== 8 || obs !== exp) begin
                fails++;
                $display("FAIL directed[%0d]: lat=%0d obs=%h want lat=8 %h", i, lat, obs, exp);
            end
            do_handshake();
            tests++;
            if (result_valid !== 1'b0 || start_ready !== 1'b1) begin
                fails++;
                $display("FAIL directed_hs[%0d]: vld=%b rdy=%b want 0 1", i, result_valid, start_ready);
            end
        end
    endtask

    task automatic test_slices();
        logic [31:0] a = $urandom;
        logic [31:0] b = $urandom;
        logic [3:0]  b0;
        logic [3:0]  b1;
        int lat;
        logic [34:0] obs;
        b0 = ~b[3:0];
        b1 = ~b[7:4];
        do_accept(a, b, 1'b1);
        tests++;
        if ({slice_a, slice_b, slice_cin} !== {a[3:0], b0, 1'b1}) begin
            fails++;
            $display("FAIL slice_n0: a=%h b=%h cin=%b want %h %h 1",
                     slice_a, slice_b, slice_cin, a[3:0], b0);
        end
        @(posedge clk);
        #1;
        tests++;
        if ({slice_a, slice_b, slice_cin} !== {a[7:4], b1, (a[3:0] >= b[3:0])}) begin
            fails++;
            $display("FAIL slice_n1: a=%h b=%h cin=%b want %h %h %b",
                     slice_a, slice_b, slice_cin, a[7:4], b1, (a[3:0] >= b[3:0]));
        end
        wait_result(lat, obs);
        tests++;
        if ({slice_a, slice_b, slice_cin} !== 9'h0 || obs !== model(a, b, 1'b1)) begin
            fails++;
            $display("FAIL slice_done: a=%h b=%h cin=%b obs=%h want 0 %h",
                     slice_a, slice_b, slice_cin, obs, model(a, b, 1'b1));
        end
        do_handshake();
    endtask

    task automatic test_stall();
        logic [31:0] a = $urandom;
        logic [31:0] b = $urandom;
        logic [31:0] na = $urandom;
        logic [31:0] nb = $urandom;
        int lat;
        logic [34:0] obs;
        logic [34:0] obs2;
        do_accept(a, b, 1'b0);
        wait_result(lat, obs);
        tests++;
        if (lat !== 8 || obs !== model(a, b, 1'b0)) begin
            fails++;
            $display("FAIL stall_first: lat=%0d obs=%h want 8 %h", lat, obs, model(a, b, 1'b0));
        end
        op_a = na;
        op_b = nb;
        sub = 1'b1;
        start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if ({result, carry_out, overflow, zero} !== obs ||
                result_valid !== 1'b1 || start_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold[%0d]: obs=%h vld=%b rdy=%b want %h 1 0",
                         i, {result, carry_out, overflow, zero}, result_valid, start_ready, obs);
            end
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        tests++;
        if (start_ready !== 1'b1 || result_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_hs: rdy=%b vld=%b want 1 0", start_ready, result_valid);
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        tests++;
        if (start_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_accept: rdy=%b want 0", start_ready);
        end
        wait_result(lat, obs2);
        tests++;
        if (lat !== 8 || obs2 !== model(na, nb, 1'b1)) begin
            fails++;
            $display("FAIL stall_second: lat=%0d obs=%h want 8 %h", lat, obs2, model(na, nb, 1'b1));
        end
        do_handshake();
    endtask

    task automatic test_reset_midrun();
        int lat;
        logic [34:0] obs;
        do_accept($urandom, $urandom, 1'($urandom_range(0, 1)));
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if (result_valid !== 1'b0 || start_ready !== 1'b1 || result !== 32'h0) begin
            fails++;
            $display("FAIL midrun_rst: vld=%b rdy=%b res=%h want 0 1 0",
                     result_valid, start_ready, result);
        end
        do_accept(32'h12345678, 32'h11111111, 1'b0);
        wait_result(lat, obs);
        tests++;
        if (lat !== 8 || obs !== {32'h23456789, 3'b000}) begin
            fails++;
            $display("FAIL midrun_next: lat=%0d obs=%h want 8 %h", lat, obs, {32'h23456789, 3'b000});
        end
        do_handshake();
    endtask

    task automatic test_random();
        int lat;
        logic [34:0] obs;
        logic [34:0] exp;
        logic [31:0] a;
        logic [31:0] b;
        logic s;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = (i % 4 == 0) ? a : $urandom;
            s = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            do_accept(a, b, s);
            wait_result(lat, obs);
            exp = model(a, b, s);
            tests++;
            if (lat !== 8 || obs !== exp) begin
                fails++;
                $display("FAIL random[%0d]: a=%h b=%h s=%b lat=%0d obs=%h want 8 %h",
                         i, a, b, s, lat, obs, exp);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            do_handshake();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_slices();
        test_stall();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
